// File: rtl/counting_sched_pkg.sv
// Shared types and the pure detector transition for counting_sched.
// Optional build macro: COUNTING_REARM_EN (HIT re-arms on the next accepted symbol).
package counting_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S12  = 2'd2,
    ST_HIT  = 2'd3
  } cnt_state_t;

  localparam logic [1:0] SYM_0 = 2'd0;
  localparam logic [1:0] SYM_1 = 2'd1;
  localparam logic [1:0] SYM_2 = 2'd2;
  localparam logic [1:0] SYM_3 = 2'd3;

  // Detects the symbol sequence 1,2,{0|3}; a repeated 1 restarts the match.
  function automatic cnt_state_t cnt_next(input cnt_state_t state, input logic [1:0] sym);
    cnt_state_t nxt;
    nxt = ST_IDLE;
    case (state)
      ST_IDLE: nxt = (sym == SYM_1) ? ST_S1 : ST_IDLE;
      ST_S1: begin
        if (sym == SYM_1)      nxt = ST_S1;
        else if (sym == SYM_2) nxt = ST_S12;
        else                   nxt = ST_IDLE;
      end
      ST_S12: begin
        if (sym == SYM_1)      nxt = ST_S1;
        else if (sym == SYM_2) nxt = ST_IDLE;
        else                   nxt = ST_HIT;
      end
      ST_HIT: begin
`ifdef COUNTING_REARM_EN
        nxt = (sym == SYM_1) ? ST_S1 : ST_IDLE;
`else
        nxt = ST_HIT;
`endif
      end
      default: nxt = ST_IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/counting_sched_if.sv
// Symbol request / grant / status bundle between the symbol sources and counting_sched.
interface counting_sched_if #(
  parameter int NCH = 4,
  parameter int IDW = 2
);
  logic [NCH-1:0]   req_valid;
  logic [2*NCH-1:0] req_sym;
  logic [NCH-1:0]   req_ready;
  logic [NCH-1:0]   clr;
  logic [NCH-1:0]   hit;
  logic             grant_valid;
  logic [IDW-1:0]   grant_id;
  logic             busy;

  modport master (
    output req_valid, req_sym, clr,
    input  req_ready, hit, grant_valid, grant_id, busy
  );

  modport slave (
    input  req_valid, req_sym, clr,
    output req_ready, hit, grant_valid, grant_id, busy
  );
endinterface

// File: rtl/counting_sched_rr_arb.sv
// Round-robin arbiter: first requester at or after ptr (wrapping) wins, one-hot grant plus index.
module rr_arb #(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input  logic [NCH-1:0] req,
  input  logic [IDW-1:0] ptr,
  output logic [NCH-1:0] gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid
);

  int             sum;
  logic [IDW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_id    = '0;
    gnt_valid = 1'b0;
    sum       = 0;
    idx       = '0;
    for (int off = 0; off < NCH; off++) begin
      sum = int'(ptr) + off;
      idx = IDW'(sum % NCH);
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt[idx]  = 1'b1;
        gnt_id    = idx;
      end
    end
  end

endmodule

// File: rtl/counting_sched.sv
// Time-multiplexed 3-symbol pattern detector over NCH channels with round-robin symbol acceptance.
// Optional build macro: COUNTING_REARM_EN (see counting_pkg::cnt_next).
module counting_sched
  import counting_pkg::*;
#(
  parameter int NCH = 4,
  parameter int IDW = 2
) (
  input logic             clk,
  input logic             rst_n,
  counting_sched_if.slave bus
);

  cnt_state_t     state_q [NCH];
  cnt_state_t     state_d [NCH];
  logic [IDW-1:0] ptr_q, ptr_d;
  logic           busy_q, busy_d;

  logic [NCH-1:0] arb_req, arb_gnt;
  logic [IDW-1:0] arb_id;
  logic           arb_valid;

  // Cleared channels sit out arbitration so the clear wins and the symbol stays pending.
  assign arb_req = bus.req_valid & ~bus.clr;

  rr_arb #(.NCH(NCH), .IDW(IDW)) u_arb (
    .req       (arb_req),
    .ptr       (ptr_q),
    .gnt       (arb_gnt),
    .gnt_id    (arb_id),
    .gnt_valid (arb_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) state_q[i] <= ST_IDLE;
      ptr_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      for (int i = 0; i < NCH; i++) state_q[i] <= state_d[i];
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      state_d[i] = state_q[i];
      if (bus.clr[i])      state_d[i] = ST_IDLE;
      else if (arb_gnt[i]) state_d[i] = cnt_next(state_q[i], bus.req_sym[2*i +: 2]);
    end
    ptr_d = ptr_q;
    if (arb_valid) ptr_d = (arb_id == IDW'(NCH - 1)) ? '0 : arb_id + 1'b1;
    busy_d = |bus.req_valid;
  end

  always_comb begin
    bus.hit = '0;
    for (int i = 0; i < NCH; i++) bus.hit[i] = (state_q[i] == ST_HIT);
    bus.req_ready   = arb_gnt;
    bus.grant_valid = arb_valid;
    bus.grant_id    = arb_id;
    bus.busy        = busy_q;
  end

endmodule

// File: tb/tb_counting_sched.sv
// Directed scoreboard bench for counting_sched (NCH=4); honours COUNTING_REARM_EN when defined.
module tb_counting_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  counting_sched_if #(.NCH(4), .IDW(2)) bus ();

  counting_sched #(.NCH(4), .IDW(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] ready;
    logic       gv;
    logic [1:0] gid;
    logic [3:0] hit;
    logic       busy;
  } exp_t;

  exp_t sb_q[$];
  int vectors = 0;
  int errs = 0;

`ifdef COUNTING_REARM_EN
  localparam logic [3:0] HIT0_AFTER_RESEND = 4'b0000;
`else
  localparam logic [3:0] HIT0_AFTER_RESEND = 4'b0001;
`endif

  task automatic applyStimulus(input logic [3:0] v, input logic [7:0] s, input logic [3:0] c);
    bus.req_valid = v;
    bus.req_sym   = s;
    bus.clr       = c;
  endtask

  task automatic pushExpect(input logic [3:0] er, input logic egv, input logic [1:0] egid,
                            input logic [3:0] eh, input logic eb);
    exp_t e;
    e.ready = er;
    e.gv    = egv;
    e.gid   = egid;
    e.hit   = eh;
    e.busy  = eb;
    sb_q.push_back(e);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    vectors++;
    assert (sb_q.size() != 0) else begin
      errs++;
      $error("[TB] FAIL %s.scoreboard observed empty queue expected an entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      vectors++;
      assert (bus.req_ready === e.ready) else begin
        errs++;
        $error("[TB] FAIL %s.req_ready observed %b expected %b", tag, bus.req_ready, e.ready);
      end
      vectors++;
      assert (bus.grant_valid === e.gv) else begin
        errs++;
        $error("[TB] FAIL %s.grant_valid observed %b expected %b", tag, bus.grant_valid, e.gv);
      end
      vectors++;
      assert (bus.grant_id === e.gid) else begin
        errs++;
        $error("[TB] FAIL %s.grant_id observed %0d expected %0d", tag, bus.grant_id, e.gid);
      end
      vectors++;
      assert (bus.hit === e.hit) else begin
        errs++;
        $error("[TB] FAIL %s.hit observed %b expected %b", tag, bus.hit, e.hit);
      end
      vectors++;
      assert (bus.busy === e.busy) else begin
        errs++;
        $error("[TB] FAIL %s.busy observed %b expected %b", tag, bus.busy, e.busy);
      end
    end
  endtask

  // Drive one cycle's inputs just after the edge and check mid-cycle, before the next edge.
  task automatic step(input string tag, input logic [3:0] v, input logic [7:0] s, input logic [3:0] c,
                      input logic [3:0] er, input logic egv, input logic [1:0] egid,
                      input logic [3:0] eh, input logic eb);
    @(posedge clk);
    #1;
    applyStimulus(v, s, c);
    pushExpect(er, egv, egid, eh, eb);
    #4;
    checkOutput(tag);
  endtask

  initial begin
    applyStimulus(4'h0, 8'h00, 4'h0);
    #3;
    pushExpect(4'h0, 1'b0, 2'd0, 4'h0, 1'b0);
    checkOutput("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    // ch0: 1,2,0 -> HIT; then a 1 while in HIT; then clear
    step("c0_s1",    4'b0001, 8'h01, 4'h0, 4'b0001, 1, 2'd0, 4'h0, 0);
    step("c0_s2",    4'b0001, 8'h02, 4'h0, 4'b0001, 1, 2'd0, 4'h0, 1);
    step("c0_s0",    4'b0001, 8'h00, 4'h0, 4'b0001, 1, 2'd0, 4'h0, 1);
    step("c0_hit",   4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'b0001, 1);
    step("c0_again", 4'b0001, 8'h01, 4'h0, 4'b0001, 1, 2'd0, 4'b0001, 0);
    step("c0_rearm", 4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, HIT0_AFTER_RESEND, 1);
    step("c0_clr",   4'b0000, 8'h00, 4'b0001, 4'b0000, 0, 2'd0, HIT0_AFTER_RESEND, 0);
    step("c0_idle",  4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'h0, 0);

    // ch1: 1,2,2,1,2,3 -> the 2,2 drops back to IDLE, final 3 hits
    step("c1_a", 4'b0010, 8'h04, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 0);
    step("c1_b", 4'b0010, 8'h08, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    step("c1_c", 4'b0010, 8'h08, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    step("c1_d", 4'b0010, 8'h04, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    step("c1_e", 4'b0010, 8'h08, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    step("c1_f", 4'b0010, 8'h0C, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    step("c1_hit", 4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'b0010, 1);
    step("c1_clr", 4'b0000, 8'h00, 4'b0010, 4'b0000, 0, 2'd0, 4'b0010, 0);
    step("c1_idle", 4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'h0, 0);

    // ch2: reach HIT, then clear collides with a pending 1 which is accepted a cycle later
    step("c2_a", 4'b0100, 8'h10, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 0);
    step("c2_b", 4'b0100, 8'h20, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 1);
    step("c2_c", 4'b0100, 8'h00, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 1);
    step("c2_clrwin", 4'b0100, 8'h10, 4'b0100, 4'b0000, 0, 2'd0, 4'b0100, 1);
    step("c2_pend",   4'b0100, 8'h10, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 1);
    step("c2_s2",     4'b0100, 8'h20, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 1);
    step("c2_s0",     4'b0100, 8'h00, 4'h0, 4'b0100, 1, 2'd2, 4'h0, 1);
    step("c2_hit",    4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'b0100, 1);
    step("c2_clr",    4'b0000, 8'h00, 4'b0100, 4'b0000, 0, 2'd0, 4'b0100, 0);
    step("c2_idle",   4'b0000, 8'h00, 4'h0, 4'b0000, 0, 2'd0, 4'h0, 0);

    // ch3 to S12, move the pointer off zero, then async reset mid-cycle
    step("c3_a", 4'b1000, 8'h40, 4'h0, 4'b1000, 1, 2'd3, 4'h0, 0);
    step("c3_b", 4'b1000, 8'h80, 4'h0, 4'b1000, 1, 2'd3, 4'h0, 1);
    step("c1_ptr", 4'b0010, 8'h00, 4'h0, 4'b0010, 1, 2'd1, 4'h0, 1);
    @(posedge clk);
    #1;
    applyStimulus(4'b1000, 8'h00, 4'h0);
    pushExpect(4'b1000, 1'b1, 2'd3, 4'h0, 1'b0);
    #2 rst_n = 1'b0;
    #1 checkOutput("rst_mid");
    applyStimulus(4'h0, 8'h00, 4'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All channels valid with symbol 0: rotation from 0; ch3 must not hit after reset
    for (int k = 0; k < 8; k++) begin
      step($sformatf("rr%0d", k), 4'hF, 8'h00, 4'h0, 4'(4'b0001 << (k % 4)), 1'b1, 2'(k % 4),
           4'h0, (k == 0) ? 1'b0 : 1'b1);
    end
    step("rr_end", 4'h0, 8'h00, 4'h0, 4'h0, 0, 2'd0, 4'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/counting_sched.md
Name: counting_sched

Overview:
- Time-multiplexes one 3-symbol pattern detector across NCH independent 2-bit symbol streams.
- Each channel keeps its own 2-bit detector state in a small register file.
- A round-robin arbiter grants one requester per cycle. The granted symbol advances that channel's state only.
- Sits between the symbol sources and the status/interrupt logic that consumes the per-channel hit flags.

Parameters:
- NCH, 4, number of requesting channels (2..16).
- IDW, 2, width of grant_id; must equal ceil(log2(NCH)).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NCH  channel i offers a symbol
- req_sym  in  2*NCH  channel i symbol at bits [2i+1:2i]
- req_ready  out  NCH  one-hot (or zero); channel i symbol accepted this cycle when valid&ready
- clr  in  NCH  per-channel synchronous clear of detector state
- hit  out  NCH  channel i detector is in HIT
- grant_valid  out  1  a symbol was accepted this cycle
- grant_id  out  IDW  index of the accepted channel; 0 when grant_valid=0
- busy  out  1  OR of req_valid, registered

Behaviour:
- Reset (rst_n=0, async):
  - all channel states = IDLE; hit=0; busy=0
  - RR pointer = 0, so channel 0 has highest priority
- Detector states (2-bit encoding): IDLE=0, S1=1, S12=2, HIT=3. Transitions on an accepted symbol s:
  - IDLE: s=1 -> S1; else IDLE
  - S1: s=1 -> S1; s=2 -> S12; else IDLE
  - S12: s=1 -> S1; s=2 -> IDLE; s=0 or 3 -> HIT
  - HIT: stays HIT (sticky) for any s
- Arbitration (combinational, same cycle):
  - Search starts at pointer and wraps modulo NCH.
  - The first i with req_valid[i]=1 and clr[i]=0 gets req_ready[i]=1.
  - grant_valid and grant_id are combinational and reflect that grant.
  - On a grant to channel k, pointer <= (k+1) mod NCH. With no grant, pointer holds.
- Handshake:
  - req_ready never asserts without req_valid.
  - A source holds req_sym stable until it sees ready.
  - Non-granted channels keep waiting. No symbol is dropped or duplicated.
- Latency:
  - Symbol accepted in cycle t updates the channel state at the edge ending t.
  - hit reflects the new state from cycle t+1. hit is decoded from the state registers (no extra flop).
- Clear:
  - clr[i]=1 forces state[i] <= IDLE at the next edge.
  - Channel i is masked out of arbitration that cycle, so clear wins over the symbol and the symbol stays pending.
- Simultaneous events:
  - Only one channel's state changes by symbol per cycle.
  - Any number of channels may be cleared in the same cycle.
- Reset mid-stream: pending requests are discarded from the block's view; sources re-present them after reset.
- busy <= |req_valid each cycle.

Optional Feature:
- Macro COUNTING_REARM_EN.
- Defined:
  - HIT is not sticky. An accepted symbol in HIT is processed as if the state were IDLE (s=1 -> S1, else IDLE).
  - hit therefore stays high until that channel's next accepted symbol.
- Undefined: HIT is sticky until clr or reset.

Decomposition:
- Package counting_pkg holds:
  - typedef cnt_state_t (2-bit) with constants ST_IDLE, ST_S1, ST_S12, ST_HIT
  - symbol constants SYM_0..SYM_3
  - function cnt_next(state, sym), the pure transition, honouring COUNTING_REARM_EN
- Sub-module rr_arb (parameter NCH): takes a request vector and the pointer, returns the one-hot grant and the encoded index.
- counting_sched instantiates rr_arb and holds the state array and pointer.

Test Plan:
- Reset, then ch0 sends 1,2,0 alone -> req_ready[0]=1 each cycle; hit[0]=1 the cycle after the third symbol; hit[3:1]=0.
- All 4 channels valid continuously from reset -> grant_id sequence 0,1,2,3,0,1,...; each channel accepted exactly once per 4 cycles.
- Ch1 sends 1,2,2,1,2,3 -> hit[1] stays 0 after the first 2,2 (state IDLE); hit[1]=1 after the final 3.
- Ch2 in HIT, clr[2]=1 while req_valid[2]=1 with sym 1 -> req_ready[2]=0 that cycle; next cycle hit[2]=0, then symbol accepted -> state S1.
- Ch0 reaches HIT, then sends 1 -> without COUNTING_REARM_EN hit[0] stays 1; with it hit[0]=0 the next cycle (state S1).
- rst_n pulled low mid-cycle while ch3 is in S12 -> hit=0, pointer=0 immediately; after release, ch3 sending 0 leaves it IDLE (no hit).
